// File: rtl/alu_uart_ctrl_pkg.sv
// Shared opcode constants, state encoding and decode helpers for the ALU/UART sequencer.
package alu_uart_ctrl_pkg;

  localparam int unsigned NB_OP    = 6;
  localparam int unsigned NB_STATE = 3;

  localparam logic [NB_OP-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OP-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OP-1:0] OP_AND = 6'h24;
  localparam logic [NB_OP-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OP-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OP-1:0] OP_NOR = 6'h27;
  localparam logic [NB_OP-1:0] OP_SRA = 6'h03;
  localparam logic [NB_OP-1:0] OP_SRL = 6'h02;

  typedef enum logic [NB_STATE-1:0] {
    ST_GET_A    = 3'd0,
    ST_GET_B    = 3'd1,
    ST_GET_OP   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_TX_START = 3'd4,
    ST_TX_WAIT  = 3'd5
  } state_t;

  function automatic logic is_valid_op(input logic [NB_OP-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_busy_state(input state_t st);
    return (st == ST_EXEC) || (st == ST_TX_START) || (st == ST_TX_WAIT);
  endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// Counts baud ticks while enabled; strobes expiry on the tick that reaches TIMEOUT_TICKS.
module byte_timeout_timer #(
  parameter int unsigned TIMEOUT_TICKS = 2048,
  parameter int unsigned NB_TIMEOUT    = 12
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_tick,
  output logic o_expire_c
);

  logic [NB_TIMEOUT-1:0] count;

  assign o_expire_c = i_enable && i_tick && (count == NB_TIMEOUT'(TIMEOUT_TICKS - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset || i_clear || o_expire_c) begin
      count <= '0;
    end else if (i_enable && i_tick) begin
      count <= count + NB_TIMEOUT'(1);
    end
  end

endmodule

// File: rtl/alu_uart_ctrl.sv
// Collects A, B, opcode from the UART, runs the ALU and launches one transmit per command.
// Inter-byte timeout enabled with `define ALU_UART_CTRL_TIMEOUT_EN.
module alu_uart_ctrl
  import alu_uart_ctrl_pkg::*;
#(
  parameter int unsigned N_DATA        = 8,
  parameter int unsigned TIMEOUT_TICKS = 2048,
  parameter int unsigned NB_TIMEOUT    = 12
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_tick,
  input  logic [N_DATA-1:0] i_rx_data,
  input  logic              i_rx_done,
  input  logic [N_DATA-1:0] i_alu_result,
  input  logic              i_tx_done,
  output logic [N_DATA-1:0] o_alu_a,
  output logic [N_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]  o_alu_op,
  output logic [N_DATA-1:0] o_tx_data,
  output logic              o_tx_start,
  output logic              o_busy,
  output logic              o_op_error,
  output logic              o_timeout
);

  state_t            state, state_next;
  logic [N_DATA-1:0] a_next, b_next, tx_data_next;
  logic [NB_OP-1:0]  op_next;
  logic              op_error_next, timeout_next;
  logic              op_byte_ok_c;
  logic              expire_c;

`ifdef ALU_UART_CTRL_TIMEOUT_EN
  byte_timeout_timer #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .NB_TIMEOUT    (NB_TIMEOUT)
  ) u_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (state_next != state),
    .i_enable   ((state == ST_GET_B) || (state == ST_GET_OP)),
    .i_tick     (i_tick),
    .o_expire_c (expire_c)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{i_tick, 32'(TIMEOUT_TICKS), 32'(NB_TIMEOUT)};
  assign expire_c = 1'b0;
`endif

  // Opcode byte must carry zeros above the opcode field.
  assign op_byte_ok_c = (i_rx_data[N_DATA-1:NB_OP] == '0) && is_valid_op(i_rx_data[NB_OP-1:0]);

  always_comb begin
    state_next    = state;
    a_next        = o_alu_a;
    b_next        = o_alu_b;
    op_next       = o_alu_op;
    tx_data_next  = o_tx_data;
    op_error_next = 1'b0;
    timeout_next  = 1'b0;
    case (state)
      ST_GET_A: begin
        if (i_rx_done) begin
          a_next     = i_rx_data;
          state_next = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (i_rx_done) begin
          b_next     = i_rx_data;
          state_next = ST_GET_OP;
        end else if (expire_c) begin
          timeout_next = 1'b1;
          state_next   = ST_GET_A;
        end
      end
      ST_GET_OP: begin
        if (i_rx_done) begin
          if (op_byte_ok_c) begin
            op_next    = i_rx_data[NB_OP-1:0];
            state_next = ST_EXEC;
          end else begin
            op_error_next = 1'b1;
            state_next    = ST_GET_A;
          end
        end else if (expire_c) begin
          timeout_next = 1'b1;
          state_next   = ST_GET_A;
        end
      end
      ST_EXEC: begin
        tx_data_next = i_alu_result;
        state_next   = ST_TX_START;
      end
      ST_TX_START: state_next = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (i_tx_done) begin
          state_next = ST_GET_A;
        end
      end
      default: state_next = ST_GET_A;
    endcase
  end

  // Status outputs are registered from next state so they line up with the state register.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state      <= ST_GET_A;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_op_error <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= state_next;
      o_alu_a    <= a_next;
      o_alu_b    <= b_next;
      o_alu_op   <= op_next;
      o_tx_data  <= tx_data_next;
      o_tx_start <= (state_next == ST_TX_START);
      o_busy     <= is_busy_state(state_next);
      o_op_error <= op_error_next;
      o_timeout  <= timeout_next;
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed scoreboard bench for alu_uart_ctrl; honours ALU_UART_CTRL_TIMEOUT_EN.
module tb_alu_uart_ctrl;
  import alu_uart_ctrl_pkg::*;

  localparam int unsigned N_DATA = 8;
`ifdef ALU_UART_CTRL_TIMEOUT_EN
  localparam int unsigned TICKS = 16;
  localparam int unsigned EXP_TIMEOUTS = 1;
`else
  localparam int unsigned TICKS = 2048;
  localparam int unsigned EXP_TIMEOUTS = 0;
`endif

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_tick = 1'b0;
  logic [N_DATA-1:0] i_rx_data = '0;
  logic              i_rx_done = 1'b0;
  logic [N_DATA-1:0] i_alu_result;
  logic              i_tx_done = 1'b0;
  logic [N_DATA-1:0] o_alu_a, o_alu_b, o_tx_data;
  logic [NB_OP-1:0]  o_alu_op;
  logic              o_tx_start, o_busy, o_op_error, o_timeout;

  int n_cmp = 0;
  int n_fail = 0;
  int n_tx = 0;
  int n_exp_tx = 0;
  int n_to = 0;
  int tx_snap;
  logic [N_DATA-1:0] exp_q[$];
  logic prev_start = 1'b0;

  alu_uart_ctrl #(
    .N_DATA        (N_DATA),
    .TIMEOUT_TICKS (TICKS),
    .NB_TIMEOUT    (12)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_tick       (i_tick),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_alu_result (i_alu_result),
    .i_tx_done    (i_tx_done),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .o_busy       (o_busy),
    .o_op_error   (o_op_error),
    .o_timeout    (o_timeout)
  );

  always #5 i_clock = ~i_clock;

  // Stand-in for the combinational ALU.
  function automatic logic [N_DATA-1:0] alu_model(input logic [N_DATA-1:0] a, b,
                                                  input logic [NB_OP-1:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return N_DATA'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      default: return '0;
    endcase
  endfunction

  assign i_alu_result = alu_model(o_alu_a, o_alu_b, o_alu_op);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transmit monitor: every launch pops the oldest expected result.
  always @(negedge i_clock) begin
    if (o_timeout === 1'b1) n_to++;
    if (o_tx_start === 1'b1) begin
      n_tx++;
      check("tx_start_one_cycle", 32'(prev_start), 32'd0);
      check("tx_expected_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_tx_data", 32'(o_tx_data), 32'(exp_q.pop_front()));
    end
    prev_start = o_tx_start;
  end

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send(input logic [N_DATA-1:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
    i_rx_data = '0;
  endtask

  // Sends a full command; returns in the cycle where o_tx_start is high.
  task automatic run_cmd(input logic [N_DATA-1:0] a, b, op, exp);
    exp_q.push_back(exp);
    n_exp_tx++;
    send(a);
    send(b);
    send(op);
    check("busy_in_exec", 32'(o_busy), 32'd1);
    check("no_start_in_exec", 32'(o_tx_start), 32'd0);
    step();
    check("tx_start", 32'(o_tx_start), 32'd1);
    check("tx_data", 32'(o_tx_data), 32'(exp));
  endtask

  task automatic finish_tx(input int gap);
    repeat (gap) step();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check("idle_after_tx_done", 32'(o_busy), 32'd0);
  endtask

  initial begin
    repeat (3) step();
    check("rst_alu_a", 32'(o_alu_a), 32'd0);
    check("rst_alu_b", 32'(o_alu_b), 32'd0);
    check("rst_alu_op", 32'(o_alu_op), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_tx_start", 32'(o_tx_start), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_op_error", 32'(o_op_error), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    i_reset = 1'b1;
    step();

    // ADD 5+3
    run_cmd(8'h05, 8'h03, 8'h20, 8'h08);
    step();
    check("tx_start_drops", 32'(o_tx_start), 32'd0);
    check("busy_in_wait", 32'(o_busy), 32'd1);
    finish_tx(2);

    // Invalid opcodes: full-byte garbage and a valid code with upper bits set
    send(8'h33);
    send(8'h44);
    send(8'hFF);
    check("op_error_ff", 32'(o_op_error), 32'd1);
    check("op_error_not_busy", 32'(o_busy), 32'd0);
    check("op_kept", 32'(o_alu_op), 32'h20);
    check("b_kept", 32'(o_alu_b), 32'h44);
    step();
    check("op_error_one_cycle", 32'(o_op_error), 32'd0);
    send(8'h11);
    check("a_after_error", 32'(o_alu_a), 32'h11);
    send(8'h02);
    send(8'h60);
    check("op_error_upper_bits", 32'(o_op_error), 32'd1);

    // Bytes arriving while busy are dropped, including one coincident with tx_done
    run_cmd(8'h11, 8'h02, 8'h25, 8'h13);
    step();
    send(8'hAA);
    send(8'hAA);
    i_rx_data = 8'hAA;
    i_rx_done = 1'b1;
    i_tx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    check("idle_after_drop", 32'(o_busy), 32'd0);
    check("a_not_overwritten", 32'(o_alu_a), 32'h11);
    run_cmd(8'h0F, 8'h01, 8'h22, 8'h0E);
    finish_tx(3);

    // Reset in the middle of a command
    tx_snap = n_tx;
    send(8'h77);
    send(8'h88);
    i_reset = 1'b0;
    step();
    check("midrst_alu_a", 32'(o_alu_a), 32'd0);
    check("midrst_alu_b", 32'(o_alu_b), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    i_reset = 1'b1;
    repeat (5) step();
    check("midrst_no_tx", 32'(n_tx), 32'(tx_snap));
    run_cmd(8'h80, 8'h02, 8'h03, 8'hE0);
    finish_tx(1);

    // Back-to-back commands; tx_done during TX_START must be ignored
    run_cmd(8'hF0, 8'h3C, 8'h24, 8'h30);
    finish_tx(1);
    run_cmd(8'h55, 8'hFF, 8'h26, 8'hAA);
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check("tx_done_ignored_in_start", 32'(o_busy), 32'd1);
    finish_tx(2);
    run_cmd(8'h0F, 8'hF0, 8'h27, 8'h00);
    finish_tx(1);
    run_cmd(8'h80, 8'h03, 8'h02, 8'h10);
    finish_tx(1);

    // Inter-byte ticks: timeout only when the feature is built in
    send(8'h01);
    for (int i = 0; i < 16; i++) begin
      i_tick = 1'b1;
      step();
      i_tick = 1'b0;
      if (i == 15) check("timeout_at_16th_tick", 32'(o_timeout), 32'(EXP_TIMEOUTS));
      step();
    end
    check("timeout_one_cycle", 32'(o_timeout), 32'd0);
`ifdef ALU_UART_CTRL_TIMEOUT_EN
    send(8'h01);
`endif
    for (int i = 0; i < 15; i++) begin
      i_tick = 1'b1;
      step();
      i_tick = 1'b0;
      step();
    end
    i_rx_data = 8'h02;
    i_rx_done = 1'b1;
    i_tick = 1'b1;
    step();
    i_rx_done = 1'b0;
    i_tick = 1'b0;
    check("rx_beats_expiry", 32'(o_timeout), 32'd0);
    check("b_after_ticks", 32'(o_alu_b), 32'h02);
    exp_q.push_back(8'h03);
    n_exp_tx++;
    send(8'h26);
    step();
    check("tx_after_ticks", 32'(o_tx_start), 32'd1);
    finish_tx(1);

    repeat (3) step();
    check("timeout_count", 32'(n_to), 32'(EXP_TIMEOUTS));
    check("tx_count", 32'(n_tx), 32'(n_exp_tx));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_uart_ctrl.md
Name: alu_uart_ctrl

Overview:
- Sequencer between the UART receiver, the combinational ALU and the UART transmitter in the TP2 datapath.
- Collects three received bytes in order: operand A, operand B, opcode.
- Presents them to the ALU, latches the result, then launches one transmit and waits for its completion before accepting a new command.
- Validates the opcode and optionally aborts a stalled command on inter-byte timeout.

Parameters:
- N_DATA, 8, width of UART byte, ALU operands and result.
- NB_OP, 6, width of ALU opcode field (low NB_OP bits of the opcode byte).
- TIMEOUT_TICKS, 2048, baud ticks allowed between bytes of one command (optional feature only).
- NB_TIMEOUT, 12, counter width; must satisfy 2^NB_TIMEOUT > TIMEOUT_TICKS.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous reset, active-low (0 = reset).
- i_tick  in  1  baud oversampling tick, same strobe that feeds the UART; used only by the timeout.
- i_rx_data  in  N_DATA  received byte; valid only when i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe: byte available.
- i_alu_result  in  N_DATA  combinational ALU output for current o_alu_a/o_alu_b/o_alu_op.
- i_tx_done  in  1  one-cycle strobe: transmitter finished the frame.
- o_alu_a  out  N_DATA  registered operand A.
- o_alu_b  out  N_DATA  registered operand B.
- o_alu_op  out  NB_OP  registered opcode.
- o_tx_data  out  N_DATA  registered result to transmit.
- o_tx_start  out  1  one-cycle transmit launch.
- o_busy  out  1  high in ST_EXEC, ST_TX_START, ST_TX_WAIT.
- o_op_error  out  1  one-cycle pulse on invalid opcode.
- o_timeout  out  1  one-cycle pulse on command abort by timeout.

Behaviour:
- Reset (i_reset=0 at posedge): state=ST_GET_A; all data outputs 0; o_tx_start, o_op_error, o_timeout, o_busy = 0. Reset mid-operation discards partial command and any pending transmit, with no tx_start.
- States and transitions (evaluated at posedge):
  - ST_GET_A: on i_rx_done, latch o_alu_a, go to ST_GET_B.
  - ST_GET_B: on i_rx_done, latch o_alu_b, go to ST_GET_OP.
  - ST_GET_OP: on i_rx_done:
    - Valid opcode: latch o_alu_op, go to ST_EXEC.
    - Invalid opcode: o_op_error=1 next cycle, go to ST_GET_A; operands and op unchanged.
  - ST_EXEC (1 cycle): o_tx_data <= i_alu_result, go to ST_TX_START.
  - ST_TX_START (1 cycle): o_tx_start=1, go to ST_TX_WAIT. i_tx_done ignored here.
  - ST_TX_WAIT: on i_tx_done, go to ST_GET_A.
- Valid opcodes (byte value, upper bits must be 0): ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRA 0x03, SRL 0x02.
- Latency: opcode rx_done at cycle t → ST_EXEC at t+1 → o_tx_data valid and o_tx_start=1 at t+2.
- o_tx_start, o_busy: decoded from the registered state; glitch-free.
- i_rx_done while o_busy=1: byte dropped, no state effect, including coincidence with i_tx_done.
- i_tx_done outside ST_TX_WAIT: ignored.
- o_op_error and o_timeout: registered, exactly one cycle wide.

Optional Feature:
- Macro: ALU_UART_CTRL_TIMEOUT_EN.
- Defined:
  - Counter increments on i_tick while in ST_GET_B or ST_GET_OP.
  - Counter clears on every accepted i_rx_done, on any state change and on reset.
  - When the count reaches TIMEOUT_TICKS: go to ST_GET_A, pulse o_timeout for one cycle, clear counter.
  - i_rx_done in the same cycle as expiry wins: byte accepted, no timeout.
- Undefined: no counter logic; o_timeout tied 0; the FSM waits indefinitely for the next byte.

Decomposition:
- Shared package: opcode constants (OP_ADD … OP_SRL), NB_OP, state encoding localparams (NB_STATE=3, ST_GET_A … ST_TX_WAIT). Reused by the ALU and the bench model.
- One natural sub-module: byte_timeout_timer (tick counter with clear, expiry strobe), instantiated only under the macro.

Test Plan:
- A=0x05, B=0x03, op=0x20, ALU model returns 0x08 → o_tx_data=0x08, single o_tx_start pulse 2 cycles after op strobe; i_tx_done returns FSM to ST_GET_A, o_busy low.
- op byte 0xFF → o_op_error one cycle, no o_tx_start, next byte 0x11 latched as o_alu_a.
- Extra rx bytes 0xAA during ST_TX_WAIT, including one coincident with i_tx_done → dropped; next command A=0x0F, B=0x01, op=0x22 yields tx_data 0x0E.
- i_reset=0 asserted after A and B received, then released → all outputs 0, state ST_GET_A, no o_tx_start ever issued.
- Macro on, TIMEOUT_TICKS=16: send A, then 16 ticks with no byte → o_timeout pulse; 15 ticks then a byte → no timeout, byte latched as B.
- Back-to-back commands with i_tx_done arriving the cycle after o_tx_start → both results transmitted in order.
